hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/hazard_ctrl_detect.sv | 19 +
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants for the hazard controller: register index width, timeout default, FSM encoding.
// No logic beyond a pure source-match helper; zero latency.
package hazard_ctrl_pkg;

  localparam int TIMEOUT_DEF = 16;
  localparam int REG_W       = 5;
  localparam int STATE_W     = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_ERR  = 2'd2;

  typedef logic [REG_W-1:0] reg_idx_t;

  function automatic logic src_hit(input logic used, input reg_idx_t rs, input reg_idx_t rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: flags an OF-stage read of the register an EX-stage load is producing.
// Purely combinational; no backpressure of its own.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic     is_ld_i,
  input  reg_idx_t rd_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  input  logic     use1_i,
  input  logic     use2_i,
  output logic     load_use_o
);

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign load_use_o = is_ld_i && (rd_i != '0) &&
                      (src_hit(use1_i, rs1_i, rd_i) || src_hit(use2_i, rs2_i, rd_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait FSM with timeout, branch flush and load-use stall.
// Outputs are combinational from state and inputs; memory stall freezes the pipe ahead of DM/WB.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             isLd_EX,
  input  logic [REG_W-1:0] rd_EX,
  input  logic [REG_W-1:0] rs1_OF,
  input  logic [REG_W-1:0] rs2_OF,
  input  logic             use1_OF,
  input  logic             use2_OF,
  input  logic             isBranchTaken_EX,
  input  logic             memOp_DM,
  input  logic             dm_ack,
  output logic             dm_req,
  output logic             pc_en,
  output logic             en_IFOF,
  output logic             en_OFEX,
  output logic             en_EXDM,
  output logic             en_DMWB,
  output logic             flush_IFOF,
  output logic             flush_OFEX,
  output logic             bubble_DMWB,
  output logic             dm_timeout,
  output logic [15:0]      stall_cnt
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;
  logic               load_use;
  logic               mem_stall;

  hazard_detect u_detect (
    .is_ld_i    (isLd_EX),
    .rd_i       (rd_EX),
    .rs1_i      (rs1_OF),
    .rs2_i      (rs2_OF),
    .use1_i     (use1_OF),
    .use2_i     (use2_OF),
    .load_use_o (load_use)
  );

  assign mem_stall = ((state_q == ST_IDLE) && memOp_DM && !dm_ack) ||
                     ((state_q == ST_WAIT) && !dm_ack) ||
                     (state_q == ST_ERR);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (memOp_DM && !dm_ack) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (dm_ack) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Priority: reset > memory stall > branch > load-use. A held branch or
  // load-use is simply re-evaluated in the release cycle from the frozen regs.
  always_comb begin
    dm_req      = 1'b0;
    pc_en       = 1'b1;
    en_IFOF     = 1'b1;
    en_OFEX     = 1'b1;
    en_EXDM     = 1'b1;
    en_DMWB     = 1'b1;
    flush_IFOF  = 1'b0;
    flush_OFEX  = 1'b0;
    bubble_DMWB = 1'b0;
    if (!rst_n) begin
      pc_en      = 1'b0;
      en_IFOF    = 1'b0;
      en_OFEX    = 1'b0;
      en_EXDM    = 1'b0;
      en_DMWB    = 1'b0;
      flush_IFOF = 1'b1;
      flush_OFEX = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: dm_req = memOp_DM;
        ST_WAIT: dm_req = 1'b1;
        default: dm_req = 1'b0;
      endcase
      if (mem_stall) begin
        pc_en       = 1'b0;
        en_IFOF     = 1'b0;
        en_OFEX     = 1'b0;
        en_EXDM     = 1'b0;
        bubble_DMWB = 1'b1;
      end else if (isBranchTaken_EX) begin
        flush_IFOF = 1'b1;
        flush_OFEX = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        en_IFOF    = 1'b0;
        flush_OFEX = 1'b1;
      end
    end
  end

  assign stall_cnt_d = (!pc_en && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dm_timeout = (state_q == ST_ERR);
  assign stall_cnt  = stall_cnt_q;

endmodule
